// File: rtl/multimem_pkg.sv
// Shared types and defaults for the ping-pong frame memory, also used by the
// loader and the scan engine.
package multimem_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  localparam int DEF_WR_WIDTH = 8;
  localparam int DEF_RATIO    = 2;
  localparam int DEF_RD_DEPTH = 2048;

endpackage

// File: rtl/multimem_bank.sv
// One frame bank: narrow lane-addressed write, registered wide read.
// Written so a byte-enabled block RAM can be inferred.
module multimem_bank
  import multimem_pkg::*;
#(
  parameter int WR_WIDTH  = DEF_WR_WIDTH,
  parameter int RATIO     = DEF_RATIO,
  parameter int RD_DEPTH  = DEF_RD_DEPTH,
  parameter int RD_ADDR_W = clog2(RD_DEPTH),
  parameter int LANE_W    = 1
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [RD_ADDR_W-1:0]      wr_word,
  input  logic [LANE_W-1:0]         wr_lane,
  input  logic [WR_WIDTH-1:0]       wr_data,
  input  logic                      rd_en,
  input  logic [RD_ADDR_W-1:0]      rd_addr,
  output logic [WR_WIDTH*RATIO-1:0] rd_data
);

  // Lane 0 occupies the least significant bits of the read word.
  logic [RATIO-1:0][WR_WIDTH-1:0] mem [RD_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_word][wr_lane] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multimem_pingpong.sv
// Double-buffered asymmetric-width frame memory: the loader fills the back bank
// while the scan engine reads the front one; banks swap only at a frame end.
module multimem_pingpong
  import multimem_pkg::*;
#(
  parameter int WR_WIDTH  = DEF_WR_WIDTH,
  parameter int RATIO     = DEF_RATIO,
  parameter int RD_DEPTH  = DEF_RD_DEPTH,
  parameter int RD_ADDR_W = clog2(RD_DEPTH),
  parameter int WR_ADDR_W = RD_ADDR_W + clog2(RATIO)
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      WrEn,
  input  logic [WR_ADDR_W-1:0]      WrAddress,
  input  logic [WR_WIDTH-1:0]       WrData,
  input  logic                      RdEn,
  input  logic [RD_ADDR_W-1:0]      RdAddress,
  output logic [WR_WIDTH*RATIO-1:0] RdData,
  output logic                      RdValid,
  input  logic                      SwapReq,
  input  logic                      FrameEnd,
  output logic                      SwapPending,
  output logic                      SwapDone,
  output logic                      FrontBank
);

  localparam int LANE_BITS = clog2(RATIO);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;

  if (((1 << LANE_BITS) != RATIO) || ((1 << RD_ADDR_W) != RD_DEPTH)) begin : g_bad_param
    $error("multimem_pingpong: RATIO and RD_DEPTH must be powers of two");
  end

  logic [RD_ADDR_W-1:0] wr_word;
  logic [LANE_W-1:0]    wr_lane;

  if (LANE_BITS == 0) begin : g_full_word
    assign wr_word = WrAddress;
    assign wr_lane = '0;
  end else begin : g_lane_split
    assign wr_word = WrAddress[WR_ADDR_W-1:LANE_BITS];
    assign wr_lane = WrAddress[LANE_BITS-1:0];
  end

  // Both ports steer on FrontBank as it stands before the edge, so a write on
  // the swap edge still lands in the outgoing back bank.
  logic [1:0][WR_WIDTH*RATIO-1:0] bank_rd;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    multimem_bank #(
      .WR_WIDTH (WR_WIDTH),
      .RATIO    (RATIO),
      .RD_DEPTH (RD_DEPTH),
      .RD_ADDR_W(RD_ADDR_W),
      .LANE_W   (LANE_W)
    ) u_bank (
      .clk    (Clock),
      .wr_en  (WrEn && (FrontBank != 1'(b))),
      .wr_word(wr_word),
      .wr_lane(wr_lane),
      .wr_data(WrData),
      .rd_en  (RdEn && (FrontBank == 1'(b))),
      .rd_addr(RdAddress),
      .rd_data(bank_rd[b])
    );
  end

  // Stage p1: bank registers hold the read word; only the selection is tracked here
  logic rd_sel_p1;
  logic rd_loaded_p1;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RdValid      <= 1'b0;
      rd_sel_p1    <= 1'b0;
      rd_loaded_p1 <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) begin
        rd_sel_p1    <= FrontBank;
        rd_loaded_p1 <= 1'b1;
      end
    end
  end

  // RAM has no reset, so the output reads as zero until the first read after reset.
  assign RdData = rd_loaded_p1 ? bank_rd[rd_sel_p1] : '0;

  swap_state_t state;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= SWAP_IDLE;
      FrontBank   <= 1'b0;
      SwapPending <= 1'b0;
      SwapDone    <= 1'b0;
    end else begin
      SwapDone <= 1'b0;
      unique case (state)
        SWAP_IDLE: begin
          if (SwapReq && FrameEnd) begin
            FrontBank <= ~FrontBank;
            SwapDone  <= 1'b1;
          end else if (SwapReq) begin
            state       <= SWAP_PENDING;
            SwapPending <= 1'b1;
          end
        end
        SWAP_PENDING: begin
          if (FrameEnd) begin
            FrontBank   <= ~FrontBank;
            SwapDone    <= 1'b1;
            SwapPending <= 1'b0;
            state       <= SWAP_IDLE;
          end
        end
        default: state <= SWAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multimem_pingpong.sv
// Bench for multimem_pingpong: three instances (RATIO 2/1/4) against a lane-level
// reference model, plus directed checks with hand-computed values.
module tb_multimem_pingpong;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        wr_en     [3];
  logic        rd_en     [3];
  logic        swap_req  [3];
  logic        frame_end [3];
  logic [11:0] wr_addr   [3];
  logic [7:0]  wr_data   [3];
  logic [10:0] rd_addr   [3];
  logic [31:0] rd_data   [3];
  logic        rd_valid  [3];
  logic        pending   [3];
  logic        done      [3];
  logic        front     [3];

  int ratio [3] = '{2, 1, 4};

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, inst, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int R  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int D  = (g == 0) ? 2048 : 256;
    localparam int RA = $clog2(D);
    localparam int WA = RA + $clog2(R);

    logic [8*R-1:0] rdw;

    multimem_pingpong #(.WR_WIDTH(8), .RATIO(R), .RD_DEPTH(D)) dut (
      .Clock      (clk),
      .ResetN     (rst_n),
      .WrEn       (wr_en[g]),
      .WrAddress  (wr_addr[g][WA-1:0]),
      .WrData     (wr_data[g]),
      .RdEn       (rd_en[g]),
      .RdAddress  (rd_addr[g][RA-1:0]),
      .RdData     (rdw),
      .RdValid    (rd_valid[g]),
      .SwapReq    (swap_req[g]),
      .FrameEnd   (frame_end[g]),
      .SwapPending(pending[g]),
      .SwapDone   (done[g]),
      .FrontBank  (front[g])
    );
    assign rd_data[g] = 32'(rdw);

    // Reference: each bank is a flat array of lanes; a read word is the
    // concatenation of R consecutive lanes. Lanes never written are masked out.
    logic [7:0]  mem   [2][D*R];
    bit          known [2][D*R];
    logic [31:0] e_data;
    logic [31:0] e_mask;
    bit          e_valid, e_pend, e_done, e_front;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e_data  = '0;
        e_mask  = '1;
        e_valid = 0;
        e_pend  = 0;
        e_done  = 0;
        e_front = 0;
      end else begin
        int wb, rb, base, la;
        rb = e_front ? 1 : 0;
        wb = 1 - rb;
        if (wr_en[g]) begin
          la = int'(wr_addr[g][WA-1:0]);
          mem[wb][la]   = wr_data[g];
          known[wb][la] = 1;
        end
        e_valid = rd_en[g];
        if (rd_en[g]) begin
          base   = int'(rd_addr[g][RA-1:0]) * R;
          e_data = '0;
          e_mask = '0;
          for (int k = 0; k < R; k++) begin
            e_data[8*k +: 8] = mem[rb][base+k];
            if (known[rb][base+k]) e_mask[8*k +: 8] = 8'hFF;
          end
        end
        e_done = frame_end[g] && (e_pend || swap_req[g]);
        if (e_done) begin
          e_front = !e_front;
          e_pend  = 0;
        end else if (swap_req[g]) begin
          e_pend = 1;
        end
      end
    end

    always @(negedge clk) begin
      check("RdValid",     g, 32'(rd_valid[g]), 32'(e_valid));
      check("SwapPending", g, 32'(pending[g]),  32'(e_pend));
      check("SwapDone",    g, 32'(done[g]),     32'(e_done));
      check("FrontBank",   g, 32'(front[g]),    32'(e_front));
      check("RdData",      g, rd_data[g] & e_mask, e_data & e_mask);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 0; rd_en[i] = 0; swap_req[i] = 0; frame_end[i] = 0;
      wr_addr[i] = '0; wr_data[i] = '0; rd_addr[i] = '0;
    end
  endtask

  task automatic wr0(input logic [11:0] a, input logic [7:0] d);
    wr_en[0] = 1; wr_addr[0] = a; wr_data[0] = d;
    cyc();
    wr_en[0] = 0;
  endtask

  task automatic rd0(input logic [10:0] a);
    rd_en[0] = 1; rd_addr[0] = a;
    cyc();
    rd_en[0] = 0;
  endtask

  task automatic swap0();
    swap_req[0] = 1; frame_end[0] = 1;
    cyc();
    swap_req[0] = 0; frame_end[0] = 0;
  endtask

  int   cnt, ndone, ntog;
  logic prev;

  task automatic step0(input logic req, input logic fe);
    swap_req[0] = req; frame_end[0] = fe;
    cyc();
    swap_req[0] = 0; frame_end[0] = 0;
    if (done[0]) ndone++;
    if (front[0] != prev) ntog++;
    prev = front[0];
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (3) cyc();
    check("reset_front",   0, 32'(front[0]),   32'd0);
    check("reset_rd_data", 0, rd_data[0],      32'd0);
    rst_n = 1;
    cyc();

    // Traffic with a pending swap, then reset mid-traffic.
    wr0(12'h010, 8'h5A);
    swap_req[0] = 1; cyc(); swap_req[0] = 0;
    check("pending_before_reset", 0, 32'(pending[0]), 32'd1);
    rd0(11'h008);
    rd_en[0] = 1; rd_addr[0] = 11'h008; swap_req[0] = 1;
    #2 rst_n = 0;
    repeat (3) begin
      cyc();
      check("rst_rd_valid", 0, 32'(rd_valid[0]), 32'd0);
      check("rst_pending",  0, 32'(pending[0]),  32'd0);
      check("rst_front",    0, 32'(front[0]),    32'd0);
      check("rst_rd_data",  0, rd_data[0],       32'd0);
    end
    rst_n = 1;
    clear_inputs();
    cyc();
    check("post_reset_pending", 0, 32'(pending[0]), 32'd0);
    check("post_reset_front",   0, 32'(front[0]),   32'd0);

    // Lane packing: lanes 0/1 of word 3.
    wr0(12'h006, 8'hA5);
    wr0(12'h007, 8'h3C);
    swap0();
    check("swap_done_pulse", 0, 32'(done[0]),  32'd1);
    check("front_after_swap", 0, 32'(front[0]), 32'd1);
    rd0(11'h003);
    check("lane_pack",       0, rd_data[0],        32'h3CA5);
    check("lane_pack_valid", 0, 32'(rd_valid[0]),  32'd1);
    check("swap_done_once",  0, 32'(done[0]),      32'd0);

    // Deferred swap: request, 29 quiet cycles reading the front, then frame end.
    wr0(12'h006, 8'h77);
    wr0(12'h007, 8'h66);
    cnt = 0;
    swap_req[0] = 1; cyc(); swap_req[0] = 0;
    if (pending[0]) cnt++;
    for (int i = 0; i < 29; i++) begin
      rd_en[0] = 1; rd_addr[0] = 11'h003;
      cyc();
      if (pending[0]) cnt++;
      check("old_front_read", 0, rd_data[0], 32'h3CA5);
    end
    rd_en[0] = 0;
    frame_end[0] = 1; cyc(); frame_end[0] = 0;
    check("pending_cycles",   0, 32'(cnt),        32'd30);
    check("deferred_front",   0, 32'(front[0]),   32'd0);
    check("deferred_done",    0, 32'(done[0]),    32'd1);
    check("deferred_pending", 0, 32'(pending[0]), 32'd0);
    cyc();
    check("deferred_done_end", 0, 32'(done[0]), 32'd0);
    rd0(11'h003);
    check("new_front_read", 0, rd_data[0], 32'h6677);

    // Double request: exactly one toggle.
    ndone = 0; ntog = 0; prev = front[0];
    step0(1, 0);
    repeat (2) step0(0, 0);
    step0(1, 0);
    repeat (11) step0(0, 0);
    step0(0, 1);
    repeat (5) step0(0, 0);
    check("double_req_done",   0, 32'(ndone),    32'd1);
    check("double_req_toggle", 0, 32'(ntog),     32'd1);
    check("double_req_front",  0, 32'(front[0]), 32'd1);

    // Swap-edge collision: front is bank 1, back is bank 0.
    wr0(12'h000, 8'h22);
    wr0(12'h001, 8'hBB);
    swap0();
    wr0(12'h000, 8'h44);
    wr0(12'h001, 8'hCC);
    wr_en[0] = 1; wr_addr[0] = 12'h000; wr_data[0] = 8'h11;
    rd_en[0] = 1; rd_addr[0] = 11'h000;
    swap_req[0] = 1; frame_end[0] = 1;
    cyc();
    clear_inputs();
    check("collision_old_front", 0, rd_data[0],      32'hBB22);
    check("collision_front",     0, 32'(front[0]),   32'd1);
    check("collision_done",      0, 32'(done[0]),    32'd1);
    rd0(11'h000);
    check("collision_write", 0, rd_data[0], 32'hCC11);

    // Random sweep over all three instances against the model.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 3; i++) begin
        wr_en[i]     = ($urandom_range(0, 1) == 1);
        wr_addr[i]   = 12'($urandom_range(0, 16 * ratio[i] - 1));
        wr_data[i]   = 8'($urandom_range(0, 255));
        rd_en[i]     = ($urandom_range(0, 1) == 1);
        rd_addr[i]   = 11'($urandom_range(0, 15));
        swap_req[i]  = ($urandom_range(0, 15) == 0);
        frame_end[i] = ($urandom_range(0, 19) == 0);
      end
      cyc();
    end
    clear_inputs();
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
